conv_feeder: RTL and testbench
==============================

# conv_feeder

Host-side transmitter that feeds the convolution core's load interface. It accepts one IMG×IMG frame of signed 16-bit pixels over a valid/ready stream and buffers the whole frame internally. It then issues the weight-load and image-load strobes and bursts the pixels stall-free on consecutive cycles, because the core has no backpressure. It waits for the core's pooling-done indication before accepting the next frame.

## Interface
Parameters:
- IMG, 7, frame edge length; frame holds N = IMG*IMG pixels
- W_GAP, 2, idle cycles between w_load pulse and i_load pulse (0..15)
- TIMEOUT, 4095, maximum cycles spent waiting for done_pooling before error

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- s_valid  in  1  host pixel valid
- s_data  in  16  host pixel, signed, raster order
- s_ready  out  1  feeder can accept a pixel
- w_load  out  1  one-cycle weight-load strobe to core
- i_load  out  1  one-cycle image-load strobe to core
- img_out  out  16  pixel stream to core img_in
- done_pooling  in  1  core's pooling-complete pulse
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_cnt  out  8  completed-frame counter, wraps 255→0
- err  out  1  sticky timeout flag, cleared only by rst

## Operation
- States: IDLE, FILL, WLOAD, GAP, ILOAD, STREAM, WAIT_DONE.
- IDLE: start=1 → FILL; write pointer cleared.
- FILL: s_ready=1. A beat is accepted on an edge with s_valid&&s_ready and written to buf[wptr]; wptr increments. Acceptance of beat N-1 → WLOAD.
- WLOAD: w_load=1 for exactly one cycle → GAP; GAP counter loaded with W_GAP.
- GAP: lasts W_GAP cycles; W_GAP=0 skips directly to ILOAD.
- ILOAD: i_load=1 for one cycle; read pointer cleared → STREAM.
- STREAM: img_out=buf[k] on the k-th STREAM cycle, k=0..N-1. After k=N-1 → WAIT_DONE.
- WAIT_DONE: done_pooling=1 → frame_done pulse, frame_cnt+1, then IDLE. Timeout counter reaching TIMEOUT → err=1, IDLE, no frame_done, frame_cnt unchanged.
- img_out is 0 outside STREAM. Pixels pass through bit-exact, with no arithmetic.
- start outside IDLE is ignored. done_pooling outside WAIT_DONE is ignored and is not remembered.
- s_valid outside FILL is ignored; s_data is not consumed.

## Timing
- Reset values: s_ready=0, w_load=0, i_load=0, img_out=0, busy=0, frame_done=0, frame_cnt=0, err=0, state=IDLE.
- All outputs are registered.
- Let E be the edge accepting the last pixel. Then:
  - s_ready is low from E.
  - w_load is high in cycle E+1.
  - i_load is high in cycle E+2+W_GAP.
  - Pixel 0 is on img_out in cycle E+3+W_GAP.
  - Pixel N-1 is on img_out in cycle E+2+W_GAP+N.
- frame_done rises the cycle after done_pooling is sampled high in WAIT_DONE. frame_cnt updates on the same edge.
- busy rises the cycle after start is sampled and falls with the return to IDLE.
- rst mid-frame returns to IDLE next edge and clears all outputs. Buffer contents are don't-care.
- If start and done_pooling are asserted in the same WAIT_DONE cycle, start is ignored.

## Structure
- Shared package conv_pkg holds:
  - the state enum;
  - DATA_W=16;
  - the N and pointer-width derivation from IMG, with pointer width = clog2(N).
- One sub-module, frame_buf: N×16 register array with synchronous write (we, waddr, wdata) and combinational read (raddr → rdata).
- The top level holds the FSM, wptr/rptr, GAP/timeout counters, frame_cnt and output registers.

## Test plan
- Basic frame: IMG=7, W_GAP=2, start, 49 pixels s_data=0..48 with s_valid held.
  - w_load one cycle after the last beat; i_load 3 cycles after that.
  - img_out=0,1,…,48 on 49 consecutive cycles.
  - done_pooling pulse → frame_done one cycle later, frame_cnt=1.
- Host stalls: s_valid toggles randomly during FILL. Exactly 49 beats are accepted, order is preserved, and signed values (-32768, 32767, -1) pass bit-exact.
- Ignored events: start pulsed during STREAM, and done_pooling pulsed during FILL. There is no state change, no frame_done, and frame_cnt is unchanged.
- Timeout: TIMEOUT=20, done_pooling never asserted.
  - err=1 exactly 20 cycles into WAIT_DONE, then IDLE.
  - frame_cnt unchanged; err persists through a subsequent successful frame.
- Reset mid-stream: rst asserted at pixel 20. All outputs are 0 the next cycle. A following full frame streams correctly from pixel 0.
- Wrap/gap: W_GAP=0 gives i_load in the cycle directly after w_load. 256 back-to-back frames wrap frame_cnt to 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and size derivations for the convolution-core frame feeder.
package conv_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WLOAD,
    S_GAP,
    S_ILOAD,
    S_STREAM,
    S_WAIT_DONE
  } state_t;

  function automatic int pix_count(input int img);
    return img * img;
  endfunction

  // Pointer width wide enough to address every pixel of one frame.
  function automatic int ptr_width(input int img);
    return (img * img > 1) ? $clog2(img * img) : 1;
  endfunction

endpackage

// File: rtl/conv_feeder_frame_buf.sv
// One-frame pixel store: synchronous write port, combinational read port.
module frame_buf
  import conv_pkg::*;
#(
  parameter int N     = 49,
  parameter int PTR_W = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [PTR_W-1:0]         waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]         raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_feeder.sv
// Buffers one IMG x IMG frame from the host, then strobes the core and bursts
// the pixels stall-free; waits for pooling-done (or times out) before the next frame.
module conv_feeder
  import conv_pkg::*;
#(
  parameter int IMG     = 7,
  parameter int W_GAP   = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     s_ready,
  output logic                     w_load,
  output logic                     i_load,
  output logic signed [DATA_W-1:0] img_out,
  input  logic                     done_pooling,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               frame_cnt,
  output logic                     err
);

  localparam int N     = pix_count(IMG);
  localparam int PTR_W = ptr_width(IMG);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] LAST_PIX = PTR_W'(N - 1);
  localparam logic [3:0]       GAP_INIT = 4'(W_GAP);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         wptr_q, wptr_d;
  logic [PTR_W-1:0]         rptr_q, rptr_d;
  logic [3:0]               gap_q, gap_d;
  logic [TO_W-1:0]          to_q, to_d;
  logic                     s_ready_q, s_ready_d;
  logic                     w_load_q, w_load_d;
  logic                     i_load_q, i_load_d;
  logic signed [DATA_W-1:0] img_q, img_d;
  logic                     busy_q, busy_d;
  logic                     fd_q, fd_d;
  logic [7:0]               fcnt_q, fcnt_d;
  logic                     err_q, err_d;

  logic                     buf_we;
  logic [PTR_W-1:0]         buf_raddr;
  logic signed [DATA_W-1:0] buf_rdata;

  frame_buf #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wptr_q),
    .wdata (s_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // rptr_q holds the index of the pixel currently on img_out; the read port
  // looks one ahead so the registered output never bubbles.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    gap_d     = gap_q;
    to_d      = to_q;
    img_d     = '0;
    fd_d      = 1'b0;
    fcnt_d    = fcnt_q;
    err_d     = err_q;
    buf_we    = 1'b0;
    buf_raddr = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          wptr_d  = '0;
        end
      end
      S_FILL: begin
        if (s_valid && s_ready_q) begin
          buf_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == LAST_PIX) state_d = S_WLOAD;
        end
      end
      S_WLOAD: begin
        if (GAP_INIT == 4'd0) begin
          state_d = S_ILOAD;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_INIT;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= 4'd1) state_d = S_ILOAD;
      end
      S_ILOAD: begin
        state_d = S_STREAM;
        rptr_d  = '0;
        img_d   = buf_rdata;
      end
      S_STREAM: begin
        if (rptr_q == LAST_PIX) begin
          state_d = S_WAIT_DONE;
          to_d    = '0;
        end else begin
          rptr_d    = rptr_q + 1'b1;
          buf_raddr = rptr_q + 1'b1;
          img_d     = buf_rdata;
        end
      end
      S_WAIT_DONE: begin
        if (done_pooling) begin
          state_d = S_IDLE;
          fd_d    = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
        end else if (to_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_FILL);
    w_load_d  = (state_d == S_WLOAD);
    i_load_d  = (state_d == S_ILOAD);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      s_ready_q <= 1'b0;
      w_load_q  <= 1'b0;
      i_load_q  <= 1'b0;
      img_q     <= '0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      fcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      s_ready_q <= s_ready_d;
      w_load_q  <= w_load_d;
      i_load_q  <= i_load_d;
      img_q     <= img_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
      fcnt_q    <= fcnt_d;
      err_q     <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign w_load     = w_load_q;
  assign i_load     = i_load_q;
  assign img_out    = img_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign frame_cnt  = fcnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder: two instances (W_GAP=2 and W_GAP=0, TIMEOUT=20) share
// all inputs; expected traces are built from the frame timing rules.
module tb_conv_feeder;

  localparam int IMG   = 7;
  localparam int N     = IMG * IMG;
  localparam int TMO   = 20;
  localparam int CAP   = 55;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic clk = 1'b0;
  logic rst, start, s_valid, done_pooling;
  logic signed [15:0] s_data;

  logic               rdy  [2];
  logic               wl   [2];
  logic               il   [2];
  logic signed [15:0] img  [2];
  logic               bsy  [2];
  logic               fd   [2];
  logic [7:0]         fcnt [2];
  logic               er   [2];

  logic signed [15:0] pix [N];
  logic signed [15:0] tr_img  [2][CAP+1];
  logic               tr_w    [2][CAP+1];
  logic               tr_i    [2][CAP+1];
  logic               tr_rdy  [2][CAP+1];
  logic               tr_busy [2][CAP+1];
  logic               tr_fd   [2][CAP+1];

  int checks = 0;
  int errors = 0;
  logic [7:0] cnt_model = 8'd0;
  logic       err_model = 1'b0;

  always #5 clk = ~clk;

  conv_feeder #(.IMG(IMG), .W_GAP(GAP_A), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[0]), .w_load(wl[0]), .i_load(il[0]), .img_out(img[0]),
    .done_pooling(done_pooling), .busy(bsy[0]), .frame_done(fd[0]),
    .frame_cnt(fcnt[0]), .err(er[0])
  );

  conv_feeder #(.IMG(IMG), .W_GAP(GAP_B), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[1]), .w_load(wl[1]), .i_load(il[1]), .img_out(img[1]),
    .done_pooling(done_pooling), .busy(bsy[1]), .frame_done(fd[1]),
    .frame_cnt(fcnt[1]), .err(er[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame: start, fill (optionally stalled), check the strobe/stream
  // trace of both instances, then either pulse done or let the timeout expire.
  task automatic run_frame(input string name, input bit stall, input bit inject,
                           input bit give_done);
    int idx;
    int guard;
    bit v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bsy[i] !== 1'b1 || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s_start inst%0d: busy=%b s_ready=%b, required busy=1 s_ready=1",
                 name, i, bsy[i], rdy[i]);
      end
    end
    idx = 0;
    guard = 0;
    while (idx < N && guard < 2000) begin
      v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_valid = v;
      s_data = v ? pix[idx] : 16'($urandom);
      done_pooling = inject && (idx == 10);
      tick();
      guard++;
      if (v) idx++;
    end
    s_valid = 1'b0;
    done_pooling = 1'b0;
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_fill: accepted=%0d, required=%0d within 2000 cycles", name, idx, N);
    end

    for (int t = 1; t <= CAP; t++) begin
      if (t > 1) tick();
      for (int i = 0; i < 2; i++) begin
        tr_img[i][t]  = img[i];
        tr_w[i][t]    = wl[i];
        tr_i[i][t]    = il[i];
        tr_rdy[i][t]  = rdy[i];
        tr_busy[i][t] = bsy[i];
        tr_fd[i][t]   = fd[i];
      end
      if (inject) begin
        start   = (t == 20);
        s_valid = 1'b1;
        s_data  = 16'sh7777;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;

    for (int i = 0; i < 2; i++) begin
      int g;
      int bad;
      g = (i == 0) ? GAP_A : GAP_B;
      bad = 0;
      for (int t = 1; t <= CAP; t++) begin
        logic signed [15:0] ei;
        logic ew;
        logic eil;
        ew  = (t == 1);
        eil = (t == 2 + g);
        ei  = (t >= 3 + g && t <= 2 + g + N) ? pix[t-3-g] : 16'sd0;
        if (tr_img[i][t] !== ei || tr_w[i][t] !== ew || tr_i[i][t] !== eil ||
            tr_rdy[i][t] !== 1'b0 || tr_busy[i][t] !== 1'b1 || tr_fd[i][t] !== 1'b0) begin
          if (bad == 0)
            $display("FAIL %s_trace inst%0d t=%0d: img=%0d w=%b i=%b rdy=%b busy=%b fd=%b, required img=%0d w=%b i=%b rdy=0 busy=1 fd=0",
                     name, i, t, tr_img[i][t], tr_w[i][t], tr_i[i][t], tr_rdy[i][t],
                     tr_busy[i][t], tr_fd[i][t], ei, ew, eil);
          bad++;
        end
      end
      checks++;
      if (bad != 0) errors++;
    end

    if (give_done) begin
      done_pooling = 1'b1;
      tick();
      done_pooling = 1'b0;
      cnt_model = cnt_model + 8'd1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (fd[i] !== 1'b1 || fcnt[i] !== cnt_model || bsy[i] !== 1'b0) begin
          errors++;
          $display("FAIL %s_done inst%0d: frame_done=%b frame_cnt=%0d busy=%b, required 1 %0d 0",
                   name, i, fd[i], fcnt[i], bsy[i], cnt_model);
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (fd[i] !== 1'b0 || fcnt[i] !== cnt_model || er[i] !== err_model) begin
          errors++;
          $display("FAIL %s_after inst%0d: frame_done=%b frame_cnt=%0d err=%b, required 0 %0d %b",
                   name, i, fd[i], fcnt[i], er[i], cnt_model, err_model);
        end
      end
    end else begin
      int bad_to [2];
      bad_to[0] = 0;
      bad_to[1] = 0;
      for (int t = CAP + 1; t <= CAP + 23; t++) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          int ws;
          logic ee;
          ws = 3 + ((i == 0) ? GAP_A : GAP_B) + N;
          ee = (t >= ws + TMO);
          if (er[i] !== ee || bsy[i] !== !ee || fd[i] !== 1'b0 || fcnt[i] !== cnt_model) begin
            if (bad_to[i] == 0)
              $display("FAIL %s_timeout inst%0d t=%0d: err=%b busy=%b fd=%b cnt=%0d, required err=%b busy=%b fd=0 cnt=%0d",
                       name, i, t, er[i], bsy[i], fd[i], fcnt[i], ee, !ee, cnt_model);
            bad_to[i]++;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bad_to[i] != 0) errors++;
      end
      err_model = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    done_pooling = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cnt_model = 8'd0;
    err_model = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 1'b0 || wl[i] !== 1'b0 || il[i] !== 1'b0 || img[i] !== 16'sd0 ||
          bsy[i] !== 1'b0 || fd[i] !== 1'b0 || fcnt[i] !== 8'd0 || er[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d: rdy=%b w=%b i=%b img=%0d busy=%b fd=%b cnt=%0d err=%b, required all 0",
                 i, rdy[i], wl[i], il[i], img[i], bsy[i], fd[i], fcnt[i], er[i]);
      end
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < N; k++) pix[k] = 16'(k);
    run_frame("basic", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stalls();
    for (int k = 0; k < N; k++) pix[k] = 16'($urandom);
    pix[3]  = -16'sd32768;
    pix[17] = 16'sd32767;
    pix[48] = -16'sd1;
    run_frame("stalls", 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_ignored();
    for (int k = 0; k < N; k++) pix[k] = 16'($urandom);
    run_frame("ignored", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    for (int k = 0; k < N; k++) pix[k] = 16'($urandom);
    run_frame("timeout", 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) pix[k] = 16'($urandom);
    run_frame("post_timeout", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < N; k++) pix[k] = 16'($urandom) | 16'h0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1;
      s_data = pix[k];
      tick();
    end
    s_valid = 1'b0;
    for (int t = 2; t <= 25; t++) tick();
    checks++;
    if (img[0] !== pix[20]) begin
      errors++;
      $display("FAIL rst_mid_pix20: img_out=%0d, required %0d", img[0], pix[20]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt_model = 8'd0;
    err_model = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rdy[i] !== 1'b0 || wl[i] !== 1'b0 || il[i] !== 1'b0 || img[i] !== 16'sd0 ||
          bsy[i] !== 1'b0 || fd[i] !== 1'b0 || fcnt[i] !== 8'd0 || er[i] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid inst%0d: rdy=%b w=%b i=%b img=%0d busy=%b fd=%b cnt=%0d err=%b, required all 0",
                 i, rdy[i], wl[i], il[i], img[i], bsy[i], fd[i], fcnt[i], er[i]);
      end
    end
    for (int k = 0; k < N; k++) pix[k] = 16'($urandom);
    run_frame("after_rst", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int frames;
    frames = 256 - int'(cnt_model);
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < N; k++) pix[k] = 16'($urandom);
      run_frame("b2b", (f % 4) == 1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (fcnt[i] !== 8'd0) begin
        errors++;
        $display("FAIL wrap inst%0d: frame_cnt=%0d, required 0", i, fcnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_ignored();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
